// File: rtl/sort_pkg.sv
// Shared definitions for the streaming sorter: order modes, lane slicing and
// the strict total order used by every compare-and-swap cell.
package sort_pkg;

    localparam logic SORT_ASC  = 1'b0;
    localparam logic SORT_DESC = 1'b1;

    // Widest key, tag and flat bus the helpers accept.
    localparam int KEY_MAX = 64;
    localparam int IDX_MAX = 16;
    localparam int BUS_MAX = 4096;

    function automatic logic [KEY_MAX-1:0] key_lane(
        input logic [BUS_MAX-1:0] bus,
        input int                 lane,
        input int                 width
    );
        logic [KEY_MAX-1:0] mask;
        mask = {KEY_MAX{1'b1}} >> (KEY_MAX - width);
        return KEY_MAX'(bus >> (lane * width)) & mask;
    endfunction

    function automatic logic [IDX_MAX-1:0] tag_lane(
        input logic [BUS_MAX-1:0] bus,
        input int                 lane,
        input int                 width
    );
        logic [IDX_MAX-1:0] mask;
        mask = {IDX_MAX{1'b1}} >> (IDX_MAX - width);
        return IDX_MAX'(bus >> (lane * width)) & mask;
    endfunction

    // Index tie-break makes the order total, so equal keys keep lane order.
    function automatic logic precedes(
        input logic [KEY_MAX-1:0] key_a,
        input logic [IDX_MAX-1:0] idx_a,
        input logic [KEY_MAX-1:0] key_b,
        input logic [IDX_MAX-1:0] idx_b,
        input logic               mode
    );
        logic key_wins;
        key_wins = (mode == SORT_DESC) ? (key_a > key_b) : (key_a < key_b);
        return key_wins || ((key_a == key_b) && (idx_a < idx_b));
    endfunction

endpackage

// File: rtl/sort_cas.sv
// Combinational compare-and-swap of two (key, idx) pairs; the element that
// precedes under the selected mode leaves on the first port.
module sort_cas
    import sort_pkg::*;
#(
    parameter int W  = 16,
    parameter int IW = 2
) (
    input  logic          mode,
    input  logic [W-1:0]  a_key,
    input  logic [IW-1:0] a_idx,
    input  logic [W-1:0]  b_key,
    input  logic [IW-1:0] b_idx,
    output logic [W-1:0]  first_key,
    output logic [IW-1:0] first_idx,
    output logic [W-1:0]  second_key,
    output logic [IW-1:0] second_idx
);

    logic swap;

    assign swap = precedes(KEY_MAX'(b_key), IDX_MAX'(b_idx),
                           KEY_MAX'(a_key), IDX_MAX'(a_idx), mode);

    assign first_key  = swap ? b_key : a_key;
    assign first_idx  = swap ? b_idx : a_idx;
    assign second_key = swap ? a_key : b_key;
    assign second_idx = swap ? a_idx : b_idx;

endmodule

// File: rtl/sort_pipe.sv
// Pipelined N-lane odd-even transposition sorter with argsort tags; one
// registered network level per stage and per-stage valid with bubble collapse.
module sort_pipe
    import sort_pkg::*;
#(
    parameter  int W  = 16,
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic            in_desc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic [N*IW-1:0] out_idx
);

    logic [N-1:0]  valid_q;
    logic [N-1:0]  desc_q;
    logic [W-1:0]  key_q [N][N];
    logic [IW-1:0] idx_q [N][N];

    logic [N-1:0]  valid_in;
    logic [N-1:0]  desc_in;
    logic [W-1:0]  key_in [N][N];
    logic [IW-1:0] idx_in [N][N];
    logic [W-1:0]  key_d  [N][N];
    logic [IW-1:0] idx_d  [N][N];

    logic [N-1:0]  stage_ready;

    if (N > 1) begin : g_chain
        assign valid_in = {valid_q[N-2:0], in_valid};
        assign desc_in  = {desc_q[N-2:0], in_desc};
    end else begin : g_single
        assign valid_in = in_valid;
        assign desc_in  = in_desc;
    end

    for (genvar s = 0; s < N; s++) begin : g_stage
        for (genvar k = 0; k < N; k++) begin : g_src
            if (s == 0) begin : g_port
                assign key_in[s][k] = W'(key_lane(BUS_MAX'(in_data), k, W));
                assign idx_in[s][k] = IW'(k);
            end else begin : g_reg
                assign key_in[s][k] = key_q[s-1][k];
                assign idx_in[s][k] = idx_q[s-1][k];
            end
        end

        // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
        for (genvar i = 0; i < N; i++) begin : g_lane
            if ((i % 2 == s % 2) && (i + 1 < N)) begin : g_cas
                sort_cas #(.W(W), .IW(IW)) u_cas (
                    .mode       (desc_in[s]),
                    .a_key      (key_in[s][i]),
                    .a_idx      (idx_in[s][i]),
                    .b_key      (key_in[s][i+1]),
                    .b_idx      (idx_in[s][i+1]),
                    .first_key  (key_d[s][i]),
                    .first_idx  (idx_d[s][i]),
                    .second_key (key_d[s][i+1]),
                    .second_idx (idx_d[s][i+1])
                );
            end else if (!((i > 0) && ((i - 1) % 2 == s % 2))) begin : g_pass
                assign key_d[s][i] = key_in[s][i];
                assign idx_d[s][i] = idx_in[s][i];
            end
        end

        // Unrolled form of !valid[s] || stage_ready[s+1]: a stage can load
        // when the sink accepts or any stage from here to the end is empty.
        assign stage_ready[s] = out_ready || !(&valid_q[N-1:s]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            desc_q  <= '0;
            for (int s = 0; s < N; s++) begin
                for (int k = 0; k < N; k++) begin
                    key_q[s][k] <= '0;
                    idx_q[s][k] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < N; s++) begin
                if (stage_ready[s]) begin
                    valid_q[s] <= valid_in[s];
                    // Payload only moves with a valid vector so the last
                    // stage keeps its contents when a bubble passes.
                    if (valid_in[s]) begin
                        desc_q[s] <= desc_in[s];
                        for (int k = 0; k < N; k++) begin
                            key_q[s][k] <= key_d[s][k];
                            idx_q[s][k] <= idx_d[s][k];
                        end
                    end
                end
            end
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = valid_q[N-1];

    for (genvar k = 0; k < N; k++) begin : g_out
        assign out_data[k*W +: W]   = key_q[N-1][k];
        assign out_idx[k*IW +: IW]  = idx_q[N-1][k];
    end

endmodule

// File: tb/tb_sort_pipe.sv
// Directed and random stimulus for sort_pipe with a queue scoreboard of
// expected sorted keys/tags pushed on acceptance and popped on delivery.
module tb_sort_pipe;
    import sort_pkg::*;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*W-1:0]  in_data = '0;
    logic            in_desc = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [N*W-1:0]  out_data;
    logic [N*IW-1:0] out_idx;

    sort_pipe #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [N*W-1:0]  q_data [$];
    logic [N*IW-1:0] q_idx  [$];
    int              q_cyc  [$];
    logic [N*W-1:0]  pend_data;
    logic [N*IW-1:0] pend_idx;

    bit              check_lat = 1'b0;
    bit              bp_mode   = 1'b0;
    bit              held_ok   = 1'b0;
    bit              saw_full  = 1'b0;
    int              bp_end    = 0;
    int              bp_acc    = 0;
    logic [N*W-1:0]  held_data;
    logic [N*IW-1:0] held_idx;

    task automatic check_bits(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [7:0] pi4(input int a, input int b, input int c, input int d);
        return {d[1:0], c[1:0], b[1:0], a[1:0]};
    endfunction

    // Selection sort: repeatedly take the best remaining lane, lowest lane on ties.
    function automatic void ref_sort(input logic [63:0] d, input logic desc,
                                     output logic [63:0] od, output logic [7:0] oi);
        bit used [N];
        int best;
        logic [15:0] kj, kb;
        for (int j = 0; j < N; j++) used[j] = 1'b0;
        od = '0;
        oi = '0;
        for (int p = 0; p < N; p++) begin
            best = -1;
            for (int j = 0; j < N; j++) begin
                if (!used[j]) begin
                    if (best < 0) best = j;
                    else begin
                        kj = d[j*16 +: 16];
                        kb = d[best*16 +: 16];
                        if (desc ? (kj > kb) : (kj < kb)) best = j;
                    end
                end
            end
            used[best] = 1'b1;
            od[p*16 +: 16] = d[best*16 +: 16];
            oi[p*2 +: 2]   = 2'(best);
        end
    endfunction

    task automatic pop_check();
        int c0;
        n_cmp++;
        assert (q_data.size() > 0) else begin
            n_err++;
            $error("FAIL spurious_output: observed out_valid=1 with data %0h expected no output", out_data);
            return;
        end
        c0 = q_cyc.pop_front();
        check_bits("out_data", 64'(out_data), 64'(q_data.pop_front()));
        check_bits("out_idx", 64'(out_idx), 64'(q_idx.pop_front()));
        if (check_lat) check_bits("latency", 64'(cyc - c0), 64'(N));
    endtask

    task automatic tick(output bit acc);
        if (bp_mode) out_ready = (cyc >= bp_end);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) pop_check();
        if (bp_mode && in_valid && cyc < bp_end) begin
            check_bits("bp_in_ready", 64'(in_ready), 64'(bp_acc < N));
            if (!in_ready) saw_full = 1'b1;
        end
        if (bp_mode && out_valid && !out_ready) begin
            if (held_ok) begin
                check_bits("hold_data", 64'(out_data), 64'(held_data));
                check_bits("hold_idx", 64'(out_idx), 64'(held_idx));
            end
            held_data = out_data;
            held_idx  = out_idx;
            held_ok   = 1'b1;
        end else begin
            held_ok = 1'b0;
        end
        if (acc) begin
            q_data.push_back(pend_data);
            q_idx.push_back(pend_idx);
            q_cyc.push_back(cyc);
            if (bp_mode) bp_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [63:0] d, input logic desc, input logic [63:0] ed,
                        input logic [7:0] ei, input bit one_shot);
        int tries;
        bit done;
        tries = 0;
        done  = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_desc   = desc;
        pend_data = ed;
        pend_idx  = ei;
        while (!done && tries < 40) begin
            tick(done);
            tries++;
        end
        check_bits("accepted", 64'(done), 64'd1);
        if (one_shot) check_bits("one_per_cycle", 64'(tries), 64'd1);
    endtask

    task automatic drain();
        int n;
        bit acc;
        n = 0;
        in_valid = 1'b0;
        while (q_data.size() > 0 && n < 60) begin
            tick(acc);
            n++;
        end
        check_bits("drained", 64'(q_data.size()), 64'd0);
    endtask

    task automatic rand_vec(input int v, output logic [63:0] d, output logic desc);
        for (int k = 0; k < N; k++)
            d[k*16 +: 16] = (v % 3 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 65535));
        desc = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [63:0] d, ed;
        logic [7:0]  ei;
        logic        desc;
        bit          acc;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_bits("rst_out_valid", 64'(out_valid), 64'd0);
        check_bits("rst_out_data", 64'(out_data), 64'd0);
        check_bits("rst_out_idx", 64'(out_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_bits("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time, unstalled
        check_lat = 1'b1;
        send(pk4(0, 6, 2, 1), SORT_DESC, pk4(6, 2, 1, 0), pi4(1, 2, 3, 0), 1'b1);
        drain();
        send(pk4(7, 2, 1, 9), SORT_DESC, pk4(9, 7, 2, 1), pi4(3, 0, 1, 2), 1'b1);
        drain();
        send(pk4(1000, 100, 10, 1), SORT_ASC, pk4(1, 10, 100, 1000), pi4(3, 2, 1, 0), 1'b1);
        drain();
        send(pk4(5, 5, 5, 5), SORT_DESC, pk4(5, 5, 5, 5), pi4(0, 1, 2, 3), 1'b1);
        send(pk4(5, 5, 5, 5), SORT_ASC, pk4(5, 5, 5, 5), pi4(0, 1, 2, 3), 1'b1);
        send(pk4(3, 8, 3, 8), SORT_DESC, pk4(8, 8, 3, 3), pi4(1, 3, 0, 2), 1'b1);
        send(pk4(65535, 0, 65535, 0), SORT_ASC, pk4(0, 0, 65535, 65535), pi4(1, 3, 0, 2), 1'b1);
        send(pk4(0, 65535, 0, 65535), SORT_DESC, pk4(65535, 65535, 0, 0), pi4(1, 3, 0, 2), 1'b1);
        drain();

        // Throughput: 20 back-to-back random vectors, mixed order modes
        for (int v = 0; v < 20; v++) begin
            rand_vec(v, d, desc);
            ref_sort(d, desc, ed, ei);
            send(d, desc, ed, ei, 1'b1);
        end
        drain();

        // Back-pressure: sink stalls 10 cycles while 8 vectors stream in
        check_lat = 1'b0;
        bp_mode   = 1'b1;
        bp_acc    = 0;
        saw_full  = 1'b0;
        held_ok   = 1'b0;
        bp_end    = cyc + 10;
        for (int v = 0; v < 8; v++) begin
            rand_vec(v + 1, d, desc);
            ref_sort(d, desc, ed, ei);
            send(d, desc, ed, ei, 1'b0);
        end
        bp_mode   = 1'b0;
        out_ready = 1'b1;
        drain();
        check_bits("bp_full_seen", 64'(saw_full), 64'd1);

        // Mid-stream reset with 3 vectors in flight and one at the output
        check_lat = 1'b1;
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            rand_vec(v + 2, d, desc);
            ref_sort(d, desc, ed, ei);
            send(d, desc, ed, ei, 1'b1);
        end
        in_valid = 1'b0;
        repeat (3) tick(acc);
        check_bits("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_bits("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_bits("mid_rst_out_data", 64'(out_data), 64'd0);
        q_data.delete();
        q_idx.delete();
        q_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check_bits("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (8) tick(acc);
        check_bits("post_rst_out_valid", 64'(out_valid), 64'd0);
        send(pk4(4, 9, 9, 1), SORT_DESC, pk4(9, 9, 4, 1), pi4(1, 2, 0, 3), 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
